// File: rtl/btn_ctrl.sv
// btn_ctrl: multi-channel push-button debouncer with press, release,
// long-press and auto-repeat events serialised into a small FIFO.
module btn_ctrl #(
  parameter int N          = 4,
  parameter int PRESC      = 1000,
  parameter int STABLE     = 8,
  parameter int LONG       = 200,
  parameter int REPEAT     = 50,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in,
  output logic [N-1:0]         level,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [$clog2(N)-1:0] evt_chan,
  output logic [1:0]           evt_code,
  output logic                 overflow,
  input  logic                 clr_ovf
);

  localparam int CW = $clog2(N);
  localparam int PW = $clog2(PRESC);
  localparam int DW = $clog2(STABLE + 1);
  localparam int HW = $clog2(LONG + REPEAT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = CW + 2;

  localparam logic [PW-1:0] PLAST = PW'(PRESC - 1);
  localparam logic [DW-1:0] DLAST = DW'(STABLE - 1);
  localparam logic [HW-1:0] HLONG = HW'(LONG);
  localparam logic [HW-1:0] HMAX  = HW'(LONG + REPEAT);
  localparam logic [AW:0]   FULL  = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] C_PRESS = 2'b00;
  localparam logic [1:0] C_REL   = 2'b01;
  localparam logic [1:0] C_LONG  = 2'b10;
  localparam logic [1:0] C_REP   = 2'b11;

  logic [N-1:0]    sync1;
  logic [N-1:0]    sync2;
  logic [PW-1:0]   pcnt;
  logic            tick;

  logic [DW-1:0]   dcnt   [N];
  logic [DW-1:0]   dcnt_n [N];
  logic [HW-1:0]   hold   [N];
  logic [HW-1:0]   hold_n [N];
  logic [HW-1:0]   hnext;
  logic [N-1:0]    level_n;
  logic [N-1:0]    ev;
  logic [1:0]      ev_code [N];

  logic [N-1:0]    pv;
  logic [1:0]      pcode [N];

  logic [CW-1:0]   ptr;
  logic [CW-1:0]   gidx;
  logic [CW-1:0]   cand;
  logic            gnt;
  logic [N-1:0]    gmask;

  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic [AW:0]     cnt;
  logic            full;
  logic            push;
  logic            pop;

  assign tick = (pcnt == PLAST);

  // two-flop synchroniser on the raw button lines
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
    end
  end

  // shared sample prescaler
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // per-channel debounce and hold timer, producing at most one event
  always_comb begin
    hnext = '0;
    for (int i = 0; i < N; i++) begin
      level_n[i]  = level[i];
      dcnt_n[i]   = dcnt[i];
      hold_n[i]   = hold[i];
      ev[i]       = 1'b0;
      ev_code[i]  = C_PRESS;
      if (tick) begin
        if (sync2[i] != level[i]) begin
          if (dcnt[i] == DLAST) begin
            level_n[i] = ~level[i];
            dcnt_n[i]  = '0;
          end else begin
            dcnt_n[i]  = dcnt[i] + 1'b1;
          end
        end else begin
          dcnt_n[i] = '0;
        end
        if (!level_n[i]) begin
          hold_n[i] = '0;
          if (level[i]) begin
            ev[i]      = 1'b1;
            ev_code[i] = C_REL;
          end
        end else if (!level[i]) begin
          hold_n[i]  = '0;
          ev[i]      = 1'b1;
          ev_code[i] = C_PRESS;
        end else begin
          hnext     = (hold[i] == HMAX) ? HMAX : hold[i] + 1'b1;
          hold_n[i] = hnext;
          if (hnext == HLONG) begin
            ev[i]      = 1'b1;
            ev_code[i] = C_LONG;
          end else if (hnext == HMAX) begin
            ev[i]      = 1'b1;
            ev_code[i] = C_REP;
            hold_n[i]  = HLONG;
          end
        end
      end
    end
  end

  // round-robin search starting after the last granted channel
  always_comb begin
    gnt   = 1'b0;
    gidx  = '0;
    cand  = '0;
    gmask = '0;
    for (int k = 1; k <= N; k++) begin
      cand = CW'((int'(ptr) + k) % N);
      if (!gnt && pv[cand]) begin
        gnt  = 1'b1;
        gidx = cand;
      end
    end
    if (full) begin
      gnt = 1'b0;
    end
    if (gnt) begin
      gmask[gidx] = 1'b1;
    end
  end

  // debounce/hold state and pending event registers
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      pv    <= '0;
      for (int i = 0; i < N; i++) begin
        dcnt[i]  <= '0;
        hold[i]  <= '0;
        pcode[i] <= '0;
      end
    end else begin
      level <= level_n;
      for (int i = 0; i < N; i++) begin
        dcnt[i] <= dcnt_n[i];
        hold[i] <= hold_n[i];
        if (ev[i]) begin
          pv[i]    <= 1'b1;
          pcode[i] <= ev_code[i];
        end else if (gmask[i]) begin
          pv[i]    <= 1'b0;
        end
      end
    end
  end

  // sticky loss flag; a new loss beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (|(ev & pv & ~gmask)) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // arbiter pointer follows the last grant
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt) begin
      ptr <= gidx;
    end
  end

  assign full      = (cnt == FULL);
  assign push      = gnt;
  assign pop       = evt_valid & evt_ready;
  assign evt_valid = (cnt != '0);
  assign {evt_chan, evt_code} = mem[rp];

  // event FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int d = 0; d < FIFO_DEPTH; d++) begin
        mem[d] <= '0;
      end
    end else begin
      if (push) begin
        mem[wp] <= {gidx, pcode[gidx]};
        wp      <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
